// File: rtl/sha_block_padder.sv
// sha_block_padder: wraps one 32-bit barcode word into a single padded
// SHA-256 message block (16 words) and streams it to the core over a
// valid/ready handshake, then waits for the core to finish or time out.
// Optional feature macro: PADDER_DROP_CNT_EN enables the DROP_CNT counter of
// HASH_START requests that arrive while busy; without it DROP_CNT is tied to 0.
module sha_block_padder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [31:0] SEND_TO_SHA,
  input  logic        HASH_START,
  output logic        READY,
  output logic        HASH_DONE,
  output logic [31:0] W_DATA,
  output logic        W_VALID,
  input  logic        W_READY,
  output logic        W_LAST,
  input  logic        CORE_DONE,
  output logic        TIMEOUT_ERR,
  output logic [7:0]  DROP_CNT
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } state_e;

  // Last counter value of the wait window; reaching it without CORE_DONE times out.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Word of the padded block: message, the '1' pad bit, zeros, 32-bit length.
  function automatic logic [31:0] block_word(input logic [3:0] idx, input logic [31:0] msg);
    case (idx)
      4'd0:    block_word = msg;
      4'd1:    block_word = 32'h8000_0000;
      4'd15:   block_word = 32'h0000_0020;
      default: block_word = 32'h0000_0000;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] msg_q, msg_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        hash_done_q, hash_done_d;
  logic        timeout_err_q, timeout_err_d;
  logic        w_valid_q, w_valid_d;
  logic        w_last_q, w_last_d;
  logic [31:0] w_data_q, w_data_d;

  // Next-state, datapath and registered-output decode for the block FSM.
  always_comb begin
    state_d       = state_q;
    msg_d         = msg_q;
    idx_d         = idx_q;
    tcnt_d        = tcnt_q;
    hash_done_d   = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (HASH_START) begin
          msg_d   = SEND_TO_SHA;
          idx_d   = 4'd0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        // W_VALID is always high in SEND, so W_READY alone completes a transfer.
        if (W_READY) begin
          if (idx_q == 4'd15) begin
            state_d = WAIT_DONE;
            tcnt_d  = 16'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          state_d = SEND;
        end
      end
      WAIT_DONE: begin
        // CORE_DONE is checked first so it wins over a same-cycle timeout.
        if (CORE_DONE) begin
          state_d     = DONE;
          hash_done_d = 1'b1;
        end else if (tcnt_q == TMO_LAST) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
          tcnt_d        = 16'd0;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    w_valid_d = (state_d == SEND);
    w_last_d  = (state_d == SEND) && (idx_d == 4'd15);
    w_data_d  = (state_d == SEND) ? block_word(idx_d, msg_d) : 32'h0000_0000;
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      msg_q         <= 32'h0000_0000;
      idx_q         <= 4'd0;
      tcnt_q        <= 16'd0;
      hash_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      w_valid_q     <= 1'b0;
      w_last_q      <= 1'b0;
      w_data_q      <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      msg_q         <= msg_d;
      idx_q         <= idx_d;
      tcnt_q        <= tcnt_d;
      hash_done_q   <= hash_done_d;
      timeout_err_q <= timeout_err_d;
      w_valid_q     <= w_valid_d;
      w_last_q      <= w_last_d;
      w_data_q      <= w_data_d;
    end
  end

  assign READY       = (state_q == IDLE);
  assign HASH_DONE   = hash_done_q;
  assign TIMEOUT_ERR = timeout_err_q;
  assign W_VALID     = w_valid_q;
  assign W_LAST      = w_last_q;
  assign W_DATA      = w_data_q;

`ifdef PADDER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Count requests that arrive while busy, saturating at 255.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (HASH_START && (state_q != IDLE) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`else
  assign DROP_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_sha_block_padder.sv
// Self-checking bench for sha_block_padder: directed and randomized blocks
// compared against a block-level reference (expected 16-word layout, expected
// completion/timeout cycle, expected drop count).
module tb_sha_block_padder;

  localparam int TMO = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] send_to_sha;
  logic        hash_start;
  logic        ready;
  logic        hash_done;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic        w_last;
  logic        core_done;
  logic        timeout_err;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int drop_exp = 0;

  always #5 clk = ~clk;

  sha_block_padder #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50   (clk),
    .RESET      (rst_n),
    .SEND_TO_SHA(send_to_sha),
    .HASH_START (hash_start),
    .READY      (ready),
    .HASH_DONE  (hash_done),
    .W_DATA     (w_data),
    .W_VALID    (w_valid),
    .W_READY    (w_ready),
    .W_LAST     (w_last),
    .CORE_DONE  (core_done),
    .TIMEOUT_ERR(timeout_err),
    .DROP_CNT   (drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_drop_cnt();
`ifdef PADDER_DROP_CNT_EN
    return drop_exp;
`else
    return 0;
`endif
  endfunction

  // One block: start, stream 16 words, then completion/timeout phase.
  // drop_mode: 0 none, 1 random, 2 every stalled cycle, 3 three pulses of 0xDEADBEEF.
  // done_at: WAIT_DONE cycle (1-based) in which CORE_DONE is pulsed, 0 = never.
  // abort_at: reset is applied while this word index is presented (-1 = never).
  task automatic run_block(input logic [31:0] msg, input int stall_word, input int stall_len,
                           input bit rnd_ready, input int drop_mode, input int done_at,
                           input int abort_at);
    logic [31:0] blk [16];
    logic [31:0] got_d [16];
    logic        got_l [16];
    logic [31:0] prev_d;
    logic        prev_stall;
    int nx, cyc, stall_left;
    int hd_n, hd_first, te_n, te_first, rdy_first, bad_n;
    nx = 0; cyc = 0; stall_left = stall_len; prev_stall = 1'b0; prev_d = 32'h0;
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = msg;
    blk[1]  = 32'h8000_0000;
    blk[15] = 32'd32;

    check_eq("ready_idle", 32'(ready), 32'd1);
    send_to_sha = msg;
    hash_start  = 1'b1;
    step();
    hash_start  = 1'b0;
    send_to_sha = $urandom();
    check_eq("valid_lat1", 32'(w_valid), 32'd1);
    check_eq("word0_lat1", w_data, msg);

    while (nx < 16 && cyc < 600) begin
      if (abort_at == nx) begin
        rst_n = 1'b0; w_ready = 1'b0; hash_start = 1'b0; core_done = 1'b0;
        #1;
        check_eq("abort_valid", 32'(w_valid), 32'd0);
        check_eq("abort_ready", 32'(ready), 32'd1);
        check_eq("abort_data", w_data, 32'h0);
        check_eq("abort_drop", 32'(drop_cnt), 32'd0);
        drop_exp = 0;
        step(); step();
        rst_n = 1'b1;
        bad_n = 0;
        for (int c = 0; c < 20; c++) begin
          if (hash_done || timeout_err || w_valid) bad_n++;
          step();
        end
        check_eq("abort_no_pulse", 32'(bad_n), 32'd0);
        return;
      end
      if (prev_stall) begin
        check_eq("hold_valid", 32'(w_valid), 32'd1);
        check_eq("hold_data", w_data, prev_d);
      end
      if (nx == stall_word && stall_left > 0) begin
        w_ready = 1'b0;
        stall_left--;
      end else begin
        w_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      case (drop_mode)
        1:       hash_start = ($urandom_range(0, 3) == 0);
        2:       hash_start = !w_ready;
        3:       hash_start = (cyc < 6) && (cyc % 2 == 0);
        default: hash_start = 1'b0;
      endcase
      send_to_sha = (drop_mode == 3) ? 32'hDEAD_BEEF : $urandom();
      if (hash_start) drop_exp = (drop_exp < 255) ? drop_exp + 1 : 255;
      core_done = 1'($urandom_range(0, 1));
      if (w_valid && w_ready) begin
        got_d[nx] = w_data;
        got_l[nx] = w_last;
        nx++;
      end
      prev_stall = w_valid && !w_ready;
      prev_d = w_data;
      step();
      cyc++;
    end
    hash_start = 1'b0; w_ready = 1'b0; core_done = 1'b0;

    check_eq("xfer_count", 32'(nx), 32'd16);
    for (int i = 0; i < nx; i++) begin
      check_eq($sformatf("word%0d", i), got_d[i], blk[i]);
      check_eq($sformatf("last%0d", i), 32'(got_l[i]), (i == 15) ? 32'd1 : 32'd0);
    end
    check_eq("valid_drop", 32'(w_valid), 32'd0);

    hd_n = 0; hd_first = 0; te_n = 0; te_first = 0; rdy_first = 0;
    for (int c = 1; c <= 14; c++) begin
      if (hash_done) begin hd_n++; if (hd_first == 0) hd_first = c; end
      if (timeout_err) begin te_n++; if (te_first == 0) te_first = c; end
      if (ready && rdy_first == 0) rdy_first = c;
      core_done = (c == done_at);
      step();
    end
    core_done = 1'b0;

    if (done_at >= 1 && done_at <= TMO) begin
      check_eq("done_pulses", 32'(hd_n), 32'd1);
      check_eq("done_cycle", 32'(hd_first), 32'(done_at + 1));
      check_eq("done_no_tmo", 32'(te_n), 32'd0);
      check_eq("done_ready", 32'(rdy_first), 32'(done_at + 2));
    end else begin
      check_eq("tmo_pulses", 32'(te_n), 32'd1);
      check_eq("tmo_cycle", 32'(te_first), 32'(TMO + 1));
      check_eq("tmo_no_done", 32'(hd_n), 32'd0);
      check_eq("tmo_ready", 32'(rdy_first), 32'(TMO + 1));
    end
    check_eq("drop_cnt", 32'(drop_cnt), 32'(exp_drop_cnt()));
  endtask

  initial begin
    rst_n = 1'b0; send_to_sha = 32'h0; hash_start = 1'b0; w_ready = 1'b0; core_done = 1'b0;
    step(); step(); step();
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_valid", 32'(w_valid), 32'd0);
    check_eq("rst_last", 32'(w_last), 32'd0);
    check_eq("rst_data", w_data, 32'h0);
    check_eq("rst_done", 32'(hash_done), 32'd0);
    check_eq("rst_tmo", 32'(timeout_err), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;

    run_block(32'h1234_ABCD, -1, 0, 1'b0, 0, 5, -1);   // back-to-back transfers
    run_block(32'h1234_ABCD, 1, 3, 1'b0, 0, 5, -1);    // 3-cycle stall at word 1
    run_block($urandom(), -1, 0, 1'b1, 0, 0, -1);      // no CORE_DONE: timeout
    run_block(32'hCAFE_0001, -1, 0, 1'b0, 3, 3, -1);   // three ignored requests
    run_block($urandom(), -1, 0, 1'b0, 0, TMO, -1);    // CORE_DONE ties timeout
    run_block($urandom(), -1, 0, 1'b0, 0, TMO + 1, -1);// late CORE_DONE ignored
    run_block($urandom(), 3, 300, 1'b0, 2, 2, -1);     // drop counter saturates
    for (int k = 0; k < 12; k++) begin
      run_block($urandom(), -1, 0, 1'b1, 1, int'($urandom_range(1, 13)), -1);
    end
    run_block($urandom(), -1, 0, 1'b0, 0, 5, 7);       // reset at word 7
    run_block($urandom(), -1, 0, 1'b1, 1, 4, -1);      // clean block after reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sha_block_padder.md
SHA_BLOCK_PADDER -- requirements
Module: sha_block_padder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning max cycles waited in WAIT_DONE for CORE_DONE (range 1..65535).
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port SEND_TO_SHA  input  32  barcode word from scanner control.
REQ-005 SHALL have port HASH_START  input  1  one-cycle request pulse qualifying SEND_TO_SHA.
REQ-006 SHALL have port READY  output  1  high only in IDLE.
REQ-007 SHALL have port HASH_DONE  output  1  one-cycle pulse on block completion.
REQ-008 SHALL have port W_DATA  output  32  message schedule word to SHA-256 core.
REQ-009 SHALL have port W_VALID  output  1  W_DATA valid.
REQ-010 SHALL have port W_READY  input  1  core accepts word.
REQ-011 SHALL have port W_LAST  output  1  high with word 15.
REQ-012 SHALL have port CORE_DONE  input  1  core finished compression.
REQ-013 SHALL have port TIMEOUT_ERR  output  1  one-cycle pulse on WAIT_DONE timeout.
REQ-014 SHALL have port DROP_CNT  output  8  count of HASH_START pulses ignored while busy.

Function
REQ-015 FSM states SHALL be IDLE, SEND, WAIT_DONE, DONE.
REQ-016 IDLE: HASH_START high SHALL latch SEND_TO_SHA into msg register, clear word index to 0, go to SEND.
REQ-017 W_VALID SHALL be high in the cycle after HASH_START is accepted (1-cycle latency), carrying word 0.
REQ-018 Block layout SHALL be: word0 = msg; word1 = 0x80000000; words2..14 = 0x00000000; word15 = 0x00000020 (32-bit length).
REQ-019 Transfer SHALL occur only when W_VALID and W_READY both high; word index (4-bit) increments by 1 per transfer.
REQ-020 W_DATA, W_LAST SHALL stay stable while W_VALID high and W_READY low; W_VALID SHALL not drop before transfer.
REQ-021 Transfer of word 15 SHALL deassert W_VALID next cycle and enter WAIT_DONE; index SHALL not wrap within a block.
REQ-022 WAIT_DONE: 16-bit timeout counter cleared on entry, increments each cycle; CORE_DONE high -> DONE.
REQ-023 Counter reaching TIMEOUT_CYCLES without CORE_DONE SHALL pulse TIMEOUT_ERR one cycle and return to IDLE with no HASH_DONE.
REQ-024 CORE_DONE and timeout in same cycle: CORE_DONE SHALL win (no TIMEOUT_ERR).
REQ-025 DONE SHALL assert HASH_DONE for exactly one cycle, then IDLE.
REQ-026 CORE_DONE outside WAIT_DONE SHALL be ignored.
REQ-027 HASH_START outside IDLE SHALL be ignored; msg register SHALL not change.
REQ-028 READY SHALL be combinationally (state == IDLE).

Reset
REQ-029 RESET low SHALL immediately force IDLE, READY=1, W_VALID=0, W_LAST=0, W_DATA=0, HASH_DONE=0, TIMEOUT_ERR=0, DROP_CNT=0, msg=0, counters=0.
REQ-030 Reset mid-SEND or mid-WAIT_DONE SHALL abandon the block; no HASH_DONE or TIMEOUT_ERR after release.
REQ-031 First HASH_START SHALL be accepted on first rising edge after RESET deasserts.

Configuration
REQ-032 With PADDER_DROP_CNT_EN defined, DROP_CNT SHALL increment by 1 per HASH_START in a non-IDLE state, saturating at 255.
REQ-033 Without PADDER_DROP_CNT_EN, DROP_CNT SHALL be constant 0 and no counter logic synthesised.

Verification
REQ-034 RESET release, HASH_START with SEND_TO_SHA=0x1234ABCD, W_READY=1 -> 16 consecutive transfers 0x1234ABCD, 0x80000000, 13x0, 0x00000020; W_LAST only on 16th.
REQ-035 Same stimulus, W_READY low for 3 cycles at word 1 -> W_DATA held 0x80000000, no index advance, 16 transfers total.
REQ-036 CORE_DONE 5 cycles into WAIT_DONE -> HASH_DONE one cycle, READY high next cycle.
REQ-037 TIMEOUT_CYCLES=10, no CORE_DONE -> TIMEOUT_ERR one cycle after 10 WAIT_DONE cycles, HASH_DONE never high.
REQ-038 PADDER_DROP_CNT_EN defined, 3 HASH_START pulses (value 0xDEADBEEF) during SEND -> DROP_CNT=3, transmitted word0 unchanged.
REQ-039 RESET low at word 7 -> W_VALID low same cycle, READY high, no HASH_DONE after release.
